// File: rtl/alsu_seq.sv
// Handshaked arithmetic/logic/shift unit with a WIDTH-cycle shift-add multiplier.
// Captures one operand bundle per transaction and reports a registered result strobe.
module alsu_seq #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  input  logic                 direction,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 invalid,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int OW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit ADD_CIN = (FULL_ADDER == "ON");

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SHF = 3'b100;
  localparam logic [2:0] OP_ROT = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t           state;
  logic             cin_reg, serial_in_reg, red_op_a_reg, red_op_b_reg;
  logic             bypass_a_reg, bypass_b_reg, direction_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       opcode_reg;

  logic [OW-1:0]    acc, mcand, acc_sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic [OW-1:0]    exec_result;
  logic [WIDTH:0]   sum;
  logic             exec_illegal, start_mul;
  logic             pick_a_byp, pick_a_red;

  // Bypass outranks every opcode, so a bypassed bundle is never illegal.
  function automatic logic illegal_of(input logic [2:0] opc, input logic ra, input logic rb,
                                      input logic ba, input logic bb);
    if (ba || bb) return 1'b0;
    if (opc[2:1] == 2'b11) return 1'b1;
    return (ra || rb) && (opc != OP_AND) && (opc != OP_XOR);
  endfunction

  assign in_ready  = (state == IDLE);
  assign start_mul = !bypass_A && !bypass_B && (opcode == OP_MUL) &&
                     !illegal_of(opcode, red_op_A, red_op_B, bypass_A, bypass_B);

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    exec_result  = '0;
    exec_illegal = illegal_of(opcode_reg, red_op_a_reg, red_op_b_reg, bypass_a_reg, bypass_b_reg);
    pick_a_byp   = bypass_a_reg && (!bypass_b_reg || PRIO_A);
    pick_a_red   = red_op_a_reg && (!red_op_b_reg || PRIO_A);
    sum          = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, (ADD_CIN && cin_reg)};
    if (bypass_a_reg || bypass_b_reg) begin
      exec_result = {{WIDTH{1'b0}}, (pick_a_byp ? a_reg : b_reg)};
    end else begin
      case (opcode_reg)
        OP_AND: begin
          if (red_op_a_reg || red_op_b_reg)
            exec_result = {{(OW-1){1'b0}}, (pick_a_red ? &a_reg : &b_reg)};
          else
            exec_result = {{WIDTH{1'b0}}, (a_reg & b_reg)};
        end
        OP_XOR: begin
          if (red_op_a_reg || red_op_b_reg)
            exec_result = {{(OW-1){1'b0}}, (pick_a_red ? ^a_reg : ^b_reg)};
          else
            exec_result = {{WIDTH{1'b0}}, (a_reg ^ b_reg)};
        end
        OP_ADD:  exec_result = {{(WIDTH-1){1'b0}}, sum};
        OP_SHF:  exec_result = direction_reg ? {out[OW-2:0], serial_in_reg}
                                             : {serial_in_reg, out[OW-1:1]};
        OP_ROT:  exec_result = direction_reg ? {out[OW-2:0], out[OW-1]}
                                             : {out[0], out[OW-1:1]};
        default: exec_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      out           <= '0;
      out_valid     <= 1'b0;
      invalid       <= 1'b0;
      leds          <= '0;
      cin_reg       <= 1'b0;
      serial_in_reg <= 1'b0;
      red_op_a_reg  <= 1'b0;
      red_op_b_reg  <= 1'b0;
      bypass_a_reg  <= 1'b0;
      bypass_b_reg  <= 1'b0;
      direction_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      opcode_reg    <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      count         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cin_reg       <= cin;
            serial_in_reg <= serial_in;
            red_op_a_reg  <= red_op_A;
            red_op_b_reg  <= red_op_B;
            bypass_a_reg  <= bypass_A;
            bypass_b_reg  <= bypass_B;
            direction_reg <= direction;
            a_reg         <= A;
            b_reg         <= B;
            opcode_reg    <= opcode;
            if (start_mul) begin
              state  <= MUL;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              count  <= '0;
            end else begin
              state <= EXEC;
            end
          end else if (invalid) begin
            leds <= ~leds;
          end
        end
        EXEC: begin
          state     <= IDLE;
          out_valid <= 1'b1;
          if (exec_illegal) begin
            out     <= '0;
            invalid <= 1'b1;
          end else begin
            out     <= exec_result;
            invalid <= 1'b0;
            leds    <= '0;
          end
        end
        MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // The final iteration's partial product goes straight to out.
          if (count == CW'(WIDTH - 1)) begin
            state     <= IDLE;
            out       <= acc_sum;
            out_valid <= 1'b1;
            invalid   <= 1'b0;
            leds      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_seq.sv
// Scoreboard bench for alsu_seq (WIDTH=3); a second instance with INPUT_PRIORITY "B"
// shares the stimulus and is checked only on the priority cases.
module tb_alsu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [2:0]  A, B, opcode;
  logic        in_ready, out_valid, invalid;
  logic [5:0]  out;
  logic [15:0] leds;
  logic        rdy_b, ov_b, inv_b;
  logic [5:0]  out_b;
  logic [15:0] leds_b;

  typedef struct {
    string      tag;
    logic [5:0] out;
    logic       inv;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alsu_seq #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cin(cin),
    .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
    .bypass_B(bypass_B), .direction(direction), .A(A), .B(B), .opcode(opcode), .out(out),
    .out_valid(out_valid), .invalid(invalid), .leds(leds));

  alsu_seq #(.WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("ON"), .LED_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .cin(cin),
    .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
    .bypass_B(bypass_B), .direction(direction), .A(A), .B(B), .opcode(opcode), .out(out_b),
    .out_valid(ov_b), .invalid(inv_b), .leds(leds_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_out"}, 64'(out), 64'(mon_e.out));
        check({mon_e.tag, "_inv"}, 64'(invalid), 64'(mon_e.inv));
        check({mon_e.tag, "_lat"}, 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic send(input string tag, input logic [2:0] opc, input logic [2:0] a,
                      input logic [2:0] b, input logic c, input logic si, input logic dir,
                      input logic ra, input logic rb, input logic ba, input logic bb,
                      input logic [5:0] eo, input logic ei, input int lat);
    exp_t e;
    bit   done;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    opcode = opc; A = a; B = b; cin = c; serial_in = si; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.tag = tag; e.out = eo; e.inv = ei; e.due = cyc + lat;
    sb.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
      else check({tag, "_busy"}, 64'(in_ready), 64'd0);
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; cin = 1'b0; serial_in = 1'b0; red_op_A = 1'b0;
    red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0; direction = 1'b0;
    A = '0; B = '0; opcode = '0;

    #3 rst = 1'b1;
    #1;
    check("rst_out", 64'(out), 64'd0);
    check("rst_leds", 64'(leds), 64'd0);
    check("rst_inv", 64'(invalid), 64'd0);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    //     tag      opc     A  B  c  si dir ra rb ba bb  out inv lat
    send("add_c",   3'b010, 7, 7, 1, 0, 0,  0, 0, 0, 0,  15, 0,  1);
    @(negedge clk);
    check("add_pulse", 64'(out_valid), 64'd0);
    check("add_hold", 64'(out), 64'd15);
    send("add_nc",  3'b010, 5, 6, 0, 0, 0,  0, 0, 0, 0,  11, 0,  1);
    send("mul75",   3'b011, 7, 5, 0, 0, 0,  0, 0, 0, 0,  35, 0,  3);
    send("mul05",   3'b011, 0, 5, 0, 0, 0,  0, 0, 0, 0,   0, 0,  3);
    send("mul77",   3'b011, 7, 7, 1, 0, 0,  0, 0, 0, 0,  49, 0,  3);

    send("ill110",  3'b110, 5, 2, 0, 0, 0,  0, 0, 0, 0,   0, 1,  1);
    check("blink0", 64'(leds), 64'h0000);
    @(negedge clk); check("blink1", 64'(leds), 64'hFFFF);
    @(negedge clk); check("blink2", 64'(leds), 64'h0000);
    @(negedge clk); check("blink3", 64'(leds), 64'hFFFF);
    send("and63",   3'b000, 6, 3, 0, 0, 0,  0, 0, 0, 0,   2, 0,  1);
    check("and_leds", 64'(leds), 64'h0000);

    send("byp_a1",  3'b000, 1, 6, 0, 0, 0,  0, 0, 1, 0,   1, 0,  1);
    send("shl_si1", 3'b100, 0, 0, 0, 1, 1,  0, 0, 0, 0,   3, 0,  1);
    send("ror",     3'b101, 0, 0, 0, 0, 0,  0, 0, 0, 0,  33, 0,  1);
    send("rol",     3'b101, 0, 0, 0, 0, 1,  0, 0, 0, 0,   3, 0,  1);
    send("shf_red", 3'b100, 7, 0, 0, 1, 1,  1, 0, 0, 0,   0, 1,  1);

    send("xor53",   3'b001, 5, 3, 0, 0, 0,  0, 0, 0, 0,   6, 0,  1);
    send("xor_rb",  3'b001, 7, 6, 0, 0, 0,  0, 1, 0, 0,   0, 0,  1);
    send("and_ra",  3'b000, 7, 2, 0, 0, 0,  1, 0, 0, 0,   1, 0,  1);
    send("red_prio",3'b000, 3, 7, 0, 0, 0,  1, 1, 0, 0,   0, 0,  1);
    check("red_prio_b", 64'(out_b), 64'd1);
    send("byp_prio",3'b010, 2, 5, 0, 0, 0,  0, 0, 1, 1,   2, 0,  1);
    check("byp_prio_b", 64'(out_b), 64'd5);
    send("add_red", 3'b010, 1, 1, 0, 0, 0,  1, 0, 0, 0,   0, 1,  1);
    send("ill111",  3'b111, 1, 1, 0, 0, 0,  0, 0, 0, 0,   0, 1,  1);
    send("mul_pre", 3'b011, 7, 5, 0, 0, 0,  0, 0, 0, 0,  35, 0,  3);

    // Abort a multiply during its second iteration cycle.
    @(negedge clk);
    opcode = 3'b011; A = 3'd7; B = 3'd5; red_op_A = 1'b0; red_op_B = 1'b0;
    bypass_A = 1'b0; bypass_B = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_out", 64'(out), 64'd0);
    check("mrst_ov", 64'(out_valid), 64'd0);
    check("mrst_rdy", 64'(in_ready), 64'd1);
    check("mrst_inv", 64'(invalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mrst_idle_out", 64'(out), 64'd0);
    send("add_post",3'b010, 1, 2, 1, 0, 0,  0, 0, 0, 0,   4, 0,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/alsu_seq.md
# alsu_seq

Parametrised, handshaked arithmetic-logic-shift unit. It is the next generation of the team's fixed 3-bit ALSU, generalised to WIDTH-bit operands and a 2·WIDTH-bit result. It adds a valid/ready input handshake, a result-valid strobe and an iterative shift-add multiplier. It sits between an operand-issuing controller and a display/LED stage.

## Interface
- WIDTH, 3, operand width in bits; must be ≥ 2.
- INPUT_PRIORITY, "A", which operand wins when both bypass or both reduction flags are set; "A" or "B".
- FULL_ADDER, "ON", "ON" adds cin_reg; "OFF" ignores cin.
- LED_WIDTH, 16, width of the error LED bus.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  unit can accept a bundle; combinational, equals state==IDLE
- cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction  in  1 each  control bits, same meaning as the existing ALSU
- A, B  in  WIDTH  operands
- opcode  in  3  operation select
- out  out  2·WIDTH  registered result
- out_valid  out  1  one-cycle strobe, result updated
- invalid  out  1  registered; the last completed transaction was illegal
- leds  out  LED_WIDTH  error indicator

## Operation
- **Accept.** A bundle is accepted on a rising edge where in_valid && in_ready. All inputs are captured into *_reg. The FSM leaves IDLE.
- **FSM states.**
  - IDLE → EXEC when opcode≠011 or the bundle is illegal.
  - IDLE → MUL otherwise.
  - EXEC → IDLE always.
  - MUL → IDLE after WIDTH iterations.
- **Decode priority**, evaluated once per bundle, first match wins:
  - Bypass: bypass_A / bypass_B select A / B. If both are set, INPUT_PRIORITY decides. The result is zero-extended.
  - 000 AND, 001 XOR:
    - red_op_A → reduction of A; red_op_B → reduction of B; both → per INPUT_PRIORITY.
    - Reduction results are 1 bit, zero-extended.
    - Otherwise bitwise A op B, zero-extended.
  - 010 ADD: A+B (+cin if FULL_ADDER "ON"). WIDTH+1-bit result, zero-extended, no truncation.
  - 011 MUL: unsigned A·B, exact in 2·WIDTH bits.
  - 100 SHIFT:
    - direction=1: out ← {out[2W-2:0], serial_in_reg}.
    - direction=0: out ← {serial_in_reg, out[2W-1:1]}.
  - 101 ROTATE: same as SHIFT, with the wrapped bit of out in place of serial_in_reg.
  - Illegal: opcode 110 or 111, or either red_op flag set on opcodes 010–101 (with no bypass).
- **Illegal result.** out ← 0 and invalid ← 1. While in IDLE with invalid=1, leds toggles (~leds) every clock (blink).
- **Any legal completion.** invalid ← 0 and leds ← 0.
- **MUL datapath.**
  - On entry, a 2W-bit accumulator is cleared, the multiplicand is loaded zero-extended and the multiplier is loaded.
  - Each MUL cycle: if multiplier[0], accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, and the iteration counter increments.
  - On the WIDTH-th iteration, out ← accumulator (including that iteration's add).
- out holds its previous value in all states until a transaction completes. SHIFT and ROTATE therefore operate on the last completed result.
- in_valid during EXEC or MUL is ignored; no buffering is done.

## Timing
- **Reset.** Asynchronous. Clears out, leds, invalid, out_valid, all *_reg, the accumulator and the counter; the FSM goes to IDLE. in_ready=1 during and after reset.
- **Reset mid-MUL.** The operation is aborted and out_valid is not asserted. out=0 after reset.
- **Non-MUL latency.** Accept at edge k; out, invalid and out_valid=1 update at edge k+1. out_valid=0 at edge k+2. in_ready is high again from edge k+1, so maximum throughput is one bundle per 2 cycles.
- **MUL latency.** Accept at edge k; MUL occupies edges k+1..k+WIDTH. out and out_valid update at edge k+WIDTH. in_ready is low from edge k until edge k+WIDTH.
- **Same-edge events.** If in_valid is high on the same edge that out_valid is asserted, that bundle is not accepted (the state is not yet IDLE). The bundle is accepted on the next edge.
- **Blink.** leds toggles on every edge while in IDLE with invalid=1, starting the edge after the invalid result. Accepting a new bundle freezes leds until that bundle completes.

## Test plan
- **Reset.** Assert rst asynchronously mid-cycle → out=0, leds=0, invalid=0, out_valid=0, in_ready=1 immediately, before the next clock edge.
- **Add, WIDTH=3, FULL_ADDER ON.** A=7, B=7, cin=1, opcode=010 → out=15 one edge after accept. out_valid pulses for exactly one cycle.
- **Multiply, WIDTH=3.** A=7, B=5, opcode=011 → in_ready low for 3 cycles, then out=35 with out_valid. Repeat with A=0 → out=0 after the same 3-cycle latency.
- **Illegal opcode.** Opcode=110 → out=0, invalid=1. leds then alternates 0xFFFF, 0x0000, 0xFFFF over the following edges. A subsequent legal AND with A=6, B=3 → out=2, invalid=0, leds=0.
- **Shift and rotate.**
  - Set out=1 via bypass_A, A=1.
  - Shift left with serial_in=1 → out=3.
  - Rotate right, direction=0 → out=6'b100001.
  - Shift or rotate with red_op_A=1 → illegal response.
- **Priorities and reset mid-MUL.**
  - bypass_A=bypass_B=1, A=2, B=5 → out=2 with INPUT_PRIORITY "A", out=5 with "B".
  - Assert rst during the 2nd MUL cycle → no out_valid, out=0, in_ready=1.
